// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/stall signals and data-memory handshake, grouped as one bundle.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata_out;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        input  mem_read, mem_write, addr, wdata, mem_rdata, mem_valid,
        output stall, done, err, rdata_out, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output mem_read, mem_write, addr, wdata, mem_rdata, mem_valid,
        input  stall, done, err, rdata_out, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LW/SW memory-stage sequencer: IDLE->REQ->WAIT->DONE, stalls the pipeline until memory answers or TIMEOUT expires.
// Min latency 3 stall cycles, done in the 4th; MEM_ALIGN_CHECK_EN adds an odd-address error that bypasses memory.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              req;
    logic              misalign;

    assign req = bus.mem_read | bus.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = bus.addr[0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_valid || (cnt == CNT_LAST)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        err_q <= misalign;
                        // A rejected odd address leaves the previous request registers intact.
                        if (!misalign) begin
                            addr_q  <= bus.addr;
                            wdata_q <= bus.wdata;
                            op_wr   <= bus.mem_write;
                        end
                    end
                end
                ST_REQ: cnt <= '0;
                ST_WAIT: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (bus.mem_valid) begin
                        err_q <= 1'b0;
                        if (!op_wr) begin
                            rdata_q <= bus.mem_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err_q <= 1'b1;
                        if (!op_wr) begin
                            rdata_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall     = ((state == ST_IDLE) && req) || (state == ST_REQ) || (state == ST_WAIT);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = (state == ST_DONE) && err_q;
    assign bus.mem_en    = (state == ST_REQ);
    assign bus.mem_wr    = (state == ST_REQ) && op_wr;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata_out = rdata_q;
endmodule
